// File: rtl/fetch_if_id.sv
// Instruction-fetch stage: PC next/hold control, imem req/ack fetch and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_wait_cnt counters.
module fetch_if_id #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_INC       = 32'd4,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_hold,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_e;

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] tgt_q, tgt_d;
    logic        redirect;
    logic        load_valid;
    logic [31:0] target;
    logic [31:0] seq_pc;

    always_comb begin
        redirect    = branch_taken | jump;
        target      = branch_taken ? branch_target : jump_target;
        seq_pc      = pc_cur + PC_INC;
        state_d     = state_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        tgt_d       = tgt_q;
        pc_next     = pc_cur;
        pc_hold     = 1'b1;
        imem_req    = 1'b0;
        load_valid  = 1'b0;

        unique case (state_q)
            BOOT: begin
                pc_next = RESET_VECTOR;
                pc_hold = 1'b0;
                state_d = FETCH;
                if (redirect) valid_d = 1'b0;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_hold = 1'b0;
                    if (redirect) begin
                        pc_next = target;
                        valid_d = 1'b0;
                    end else begin
                        pc_next = seq_pc;
                        if (hazard_stall) begin
                            buf_instr_d = imem_rdata;
                            buf_pc4_d   = seq_pc;
                            state_d     = HOLD;
                        end else begin
                            instr_d    = imem_rdata;
                            pc4_d      = seq_pc;
                            valid_d    = 1'b1;
                            load_valid = 1'b1;
                        end
                    end
                end else if (redirect) begin
                    // Request already in flight: wait for its ack before moving PC.
                    valid_d = 1'b0;
                    tgt_d   = target;
                    state_d = DRAIN;
                end else if (!hazard_stall) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next = target;
                    pc_hold = 1'b0;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!hazard_stall) begin
                    instr_d    = buf_instr_q;
                    pc4_d      = buf_pc4_q;
                    valid_d    = 1'b1;
                    load_valid = 1'b1;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (redirect) begin
                    valid_d = 1'b0;
                    tgt_d   = target;
                end
                if (imem_ack) begin
                    pc_hold = 1'b0;
                    pc_next = redirect ? target : tgt_q;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            valid_q     <= 1'b0;
            instr_q     <= NOP_INSTR;
            pc4_q       <= 32'd0;
            buf_instr_q <= NOP_INSTR;
            buf_pc4_q   <= 32'd0;
            tgt_q       <= RESET_VECTOR;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            tgt_q       <= tgt_d;
        end
    end

    assign imem_addr   = pc_cur;
    assign if_id_instr = valid_q ? instr_q : NOP_INSTR;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] wait_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            wait_cnt_q  <= 32'd0;
        end else begin
            if (load_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (imem_req && !imem_ack) wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_wait_cnt  = wait_cnt_q;
`else
    logic perf_unused;
    assign perf_unused = load_valid;
`endif

endmodule

// File: tb/tb_fetch_if_id.sv
// Bench for fetch_if_id: PC register and wait-state memory models around the DUT,
// a queue-based reference of the fetch stage, directed pins plus randomized traffic.
module tb_fetch_if_id;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc_cur, pc_next;
    logic        pc_hold;
    logic        hazard_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_wait_cnt;
`endif

    always #5 clk = ~clk;

    fetch_if_id dut (
        .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next), .pc_hold(pc_hold),
        .hazard_stall(hazard_stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    // PC register driven by the stage's next/hold controls
    logic [31:0] pc_q = 32'hDEAD_BEEF;
    assign pc_cur = pc_q;
    always @(posedge clk) if (!pc_hold) pc_q <= pc_next;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr, m_pc4;
    logic [63:0] held[$];
    logic [31:0] drain[$];
    int unsigned m_fcnt, m_wcnt;

    // memory model and stimulus control
    int mcnt = 0;
    int mem_wait = 0;
    bit rand_wait = 1'b0;
    bit rst_req = 1'b0;

    // snapshot of DUT outputs at the last compare point
    logic        s_req, s_hold, s_valid;
    logic [31:0] s_next, s_addr, s_instr, s_pc4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit st, input bit br, input logic [31:0] bt,
                        input bit jp, input logic [31:0] jt);
        bit          redirect, ack, e_req, e_hold, n_boot, n_valid;
        logic [31:0] tgt, seq, e_next, n_pc, n_instr, n_pc4;
        int unsigned n_fcnt, n_wcnt;
        rst_n = !rst_req;
        hazard_stall = st; branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt;
        #1;
        if (imem_req && mcnt >= mem_wait) begin
            imem_ack = 1'b1; imem_rdata = imem_addr ^ K;
        end else begin
            imem_ack = 1'b0; imem_rdata = $urandom;
        end
        @(negedge clk);
        s_req = imem_req; s_hold = pc_hold; s_valid = if_id_valid; s_next = pc_next;
        s_addr = imem_addr; s_instr = if_id_instr; s_pc4 = if_id_pc4;
        ack = imem_ack;
        if (!rst_n) begin
            chk("rst_pc_next", pc_next, RV);
            chk("rst_pc_hold", {31'd0, pc_hold}, 32'd0);
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
            chk("rst_instr", if_id_instr, NOP);
            chk("rst_pc4", if_id_pc4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
            chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
            chk("rst_perf_wait", perf_wait_cnt, 32'd0);
`endif
            m_boot = 1'b1; m_pc = RV; m_valid = 1'b0; m_instr = NOP; m_pc4 = 32'd0;
            held.delete(); drain.delete(); m_fcnt = 0; m_wcnt = 0;
        end else begin
            redirect = br | jp;
            tgt = br ? bt : jt;
            seq = m_pc + 32'd4;
            e_req = 1'b0; e_hold = 1'b1; e_next = 32'd0;
            n_boot = m_boot; n_valid = m_valid; n_instr = m_instr; n_pc4 = m_pc4;
            n_fcnt = m_fcnt; n_wcnt = m_wcnt;
            if (m_boot) begin
                e_hold = 1'b0; e_next = RV; n_boot = 1'b0;
                if (redirect) n_valid = 1'b0;
            end else if (held.size() != 0) begin
                if (redirect) begin
                    e_hold = 1'b0; e_next = tgt; n_valid = 1'b0; held.delete();
                end else if (!st) begin
                    {n_instr, n_pc4} = held.pop_front(); n_valid = 1'b1; n_fcnt++;
                end
            end else begin
                e_req = 1'b1;
                if (!ack) n_wcnt++;
                if (drain.size() != 0) begin
                    if (redirect) begin n_valid = 1'b0; drain[0] = tgt; end
                    if (ack) begin e_hold = 1'b0; e_next = drain.pop_front(); end
                end else if (ack) begin
                    e_hold = 1'b0;
                    if (redirect) begin
                        e_next = tgt; n_valid = 1'b0;
                    end else begin
                        e_next = seq;
                        if (st) held.push_back({m_pc ^ K, seq});
                        else begin n_instr = m_pc ^ K; n_pc4 = seq; n_valid = 1'b1; n_fcnt++; end
                    end
                end else if (redirect) begin
                    n_valid = 1'b0; drain.push_back(tgt);
                end else if (!st) begin
                    n_valid = 1'b0;
                end
            end
            chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
            chk("pc_hold", {31'd0, pc_hold}, {31'd0, e_hold});
            if (!e_hold) chk("pc_next", pc_next, e_next);
            chk("imem_addr", imem_addr, m_pc);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            chk("if_id_instr", if_id_instr, m_valid ? m_instr : NOP);
            if (m_valid) chk("if_id_pc4", if_id_pc4, m_pc4);
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
            chk("perf_wait_cnt", perf_wait_cnt, m_wcnt);
`endif
            n_pc = e_hold ? m_pc : e_next;
            m_boot = n_boot; m_pc = n_pc; m_valid = n_valid; m_instr = n_instr; m_pc4 = n_pc4;
            m_fcnt = n_fcnt; m_wcnt = n_wcnt;
        end
        @(posedge clk);
        if (!rst_n) mcnt = 0;
        else if (s_req && ack) begin
            mcnt = 0;
            if (rand_wait) mem_wait = $urandom_range(0, 3);
        end else if (s_req) mcnt++;
        #1;
    endtask

    task automatic idle(input bit st);
        step(st, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        int rst_left;
        @(posedge clk); #1;
        // reset held for three edges
        rst_req = 1'b1;
        repeat (3) idle(1'b0);
        rst_req = 1'b0;

        idle(1'b0);                                      // BOOT
        chk("boot_req", {31'd0, s_req}, 32'd0);
        chk("boot_next", s_next, 32'h0);
        idle(1'b0);
        chk("first_req", {31'd0, s_req}, 32'd1);
        chk("first_addr", s_addr, 32'h0);
        chk("first_valid", {31'd0, s_valid}, 32'd0);
        idle(1'b0);
        chk("stream_pc4_a", s_pc4, 32'd4);
        chk("stream_instr_a", s_instr, 32'hA5A5_0000);
        idle(1'b0);
        chk("stream_pc4_b", s_pc4, 32'd8);
        chk("stream_instr_b", s_instr, 32'hA5A5_0004);

        mem_wait = 2;                                    // two wait cycles
        idle(1'b0);
        chk("wait_hold_a", {31'd0, s_hold}, 32'd1);
        chk("wait_addr_a", s_addr, 32'd12);
        idle(1'b0);
        chk("wait_hold_b", {31'd0, s_hold}, 32'd1);
        chk("wait_addr_b", s_addr, 32'd12);
        chk("wait_bubble", {31'd0, s_valid}, 32'd0);
        idle(1'b0);
        chk("wait_ack_hold", {31'd0, s_hold}, 32'd0);
        chk("wait_ack_next", s_next, 32'd16);

        mem_wait = 0;                                    // stall for three cycles at ack
        idle(1'b1);
        chk("stall_valid", {31'd0, s_valid}, 32'd1);
        chk("stall_pc4", s_pc4, 32'd16);
        idle(1'b1);
        idle(1'b1);
        chk("hold_req", {31'd0, s_req}, 32'd0);
        chk("hold_pc_hold", {31'd0, s_hold}, 32'd1);
        chk("hold_frozen_pc4", s_pc4, 32'd16);
        chk("hold_pc_once", s_addr, 32'd20);
        idle(1'b0);
        mem_wait = 2;
        idle(1'b0);
        chk("release_pc4", s_pc4, 32'd20);
        chk("release_instr", s_instr, 32'hA5A5_0010);
        chk("release_valid", {31'd0, s_valid}, 32'd1);

        step(1'b0, 1'b1, 32'h100, 1'b0, 32'd0);          // branch during a wait cycle
        idle(1'b0);
        chk("drain_next", s_next, 32'h100);
        chk("drain_hold", {31'd0, s_hold}, 32'd0);
        chk("drain_valid", {31'd0, s_valid}, 32'd0);
        mem_wait = 0;
        idle(1'b0);
        chk("branch_addr", s_addr, 32'h100);
        chk("branch_valid", {31'd0, s_valid}, 32'd0);

        idle(1'b1);                                      // both redirects plus stall
        step(1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
        chk("prio_next", s_next, 32'h200);
        chk("prio_hold", {31'd0, s_hold}, 32'd0);
        idle(1'b1);
        chk("prio_addr", s_addr, 32'h200);
        chk("prio_drop", {31'd0, s_valid}, 32'd0);
        idle(1'b0);
        idle(1'b0);
        chk("prio_pc4", s_pc4, 32'h204);
        chk("prio_instr", s_instr, 32'hA5A5_0200);

        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);    // PC+4 wrap
        chk("wrap_redirect", s_next, 32'hFFFF_FFFC);
        idle(1'b0);
        chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
        idle(1'b0);
        chk("wrap_pc4", s_pc4, 32'h0);
        chk("wrap_instr", s_instr, 32'h5A5A_FFFC);
        chk("wrap_valid", {31'd0, s_valid}, 32'd1);
        chk("wrap_addr_next", s_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_lit", perf_fetch_cnt, 32'd9);
        chk("perf_wait_lit", perf_wait_cnt, 32'd4);
`endif

        rand_wait = 1'b1;                                // randomized traffic
        rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rst_left == 0 && $urandom_range(0, 249) == 0) rst_left = 2;
            rst_req = (rst_left != 0);
            if (rst_left != 0) rst_left--;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC);
        end
        rst_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
